// File: rtl/dm_port_arbiter_pkg.sv
// Constants shared by the data-memory port arbiter, the data memory and the controller:
// owner tag encodings, access width codes and the starvation counter width.
package dm_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    // Wide enough for the largest allowed STARVE_LIMIT (15)
    localparam int CNT_W = 4;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_starve_counter.sv
// Saturating wait counter: counts consecutive cycles a requester was passed over
// and flags when it has reached LIMIT.
module dm_port_arbiter_starve_counter #(
    parameter int LIMIT = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    assign at_limit = (cnt == LIM);

    // Clear has priority so a grant in a waiting cycle restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_limit)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Single data-memory port shared by the memory stage (fixed priority) and a debug/loader
// port; starvation forcing gives DBG a slot, and a registered owner tag routes read data.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wd,
    input  logic [1:0]        cpu_width,
    input  logic              cpu_extend,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rd,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wd,
    output logic              dbg_gnt,
    output logic              dbg_err,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rd,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic [1:0]        mem_width,
    output logic              mem_extend,
    input  logic [31:0]       mem_rd
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wd;
        logic [1:0]        width;
        logic              extend;
    } mem_req_t;

    logic [CNT_W-1:0] starve_cnt;
    logic             at_limit;
    logic             force_dbg;
    logic             dbg_misalign;
    logic             grant_cpu;
    logic             grant_dbg;
    mem_req_t         cpu_r;
    mem_req_t         dbg_r;
    mem_req_t         sel;
    owner_e           owner;
    owner_e           owner_nxt;

    assign cpu_r = '{we: cpu_we, addr: cpu_addr, wd: cpu_wd, width: cpu_width, extend: cpu_extend};
    assign dbg_r = '{we: dbg_we, addr: dbg_addr, wd: dbg_wd, width: WIDTH_WORD, extend: 1'b0};

    assign force_dbg    = at_limit && dbg_req;
    assign dbg_misalign = !word_aligned(dbg_addr[1:0]);

    // Grants are held off entirely during reset so every output reads 0
    always_comb begin
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        if (rst_n) begin
            if (force_dbg)
                grant_dbg = 1'b1;
            else if (cpu_req)
                grant_cpu = 1'b1;
            else if (dbg_req)
                grant_dbg = 1'b1;
        end
    end

    // A misaligned DBG grant consumes the request but never reaches memory
    always_comb begin
        sel    = '0;
        mem_en = 1'b0;
        if (grant_cpu) begin
            sel    = cpu_r;
            mem_en = 1'b1;
        end else if (grant_dbg && !dbg_misalign) begin
            sel    = dbg_r;
            mem_en = 1'b1;
        end
    end

    assign mem_we     = sel.we;
    assign mem_addr   = sel.addr;
    assign mem_wd     = sel.wd;
    assign mem_width  = sel.width;
    assign mem_extend = sel.extend;

    assign cpu_stall = rst_n && cpu_req && !grant_cpu;
    assign dbg_gnt   = grant_dbg;
    assign dbg_err   = grant_dbg && dbg_misalign;

    dm_port_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (dbg_req && !dbg_gnt),
        .clr      (dbg_gnt || !dbg_req),
        .cnt      (starve_cnt),
        .at_limit (at_limit)
    );

    // Every cycle is tagged on its own, so back-to-back reads stream one response per cycle
    always_comb begin
        owner_nxt = OWN_NONE;
        if (mem_en && !mem_we)
            owner_nxt = grant_cpu ? OWN_CPU : OWN_DBG;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            owner <= OWN_NONE;
        else
            owner <= owner_nxt;
    end

    // Gating with rst_n drops a read whose response would land in a reset cycle
    assign cpu_rvalid = rst_n && (owner == OWN_CPU);
    assign dbg_rvalid = rst_n && (owner == OWN_DBG);
    assign cpu_rd     = cpu_rvalid ? mem_rd : 32'h0;
    assign dbg_rd     = dbg_rvalid ? mem_rd : 32'h0;

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
Arbitrates the single data-memory port between the pipeline memory stage (CPU requester) and a debug/loader requester (DBG).
- Sits between stage_mm and dm.
- CPU has fixed priority. A starvation counter guarantees DBG a slot, and the CPU is stalled for that cycle.
- Routes registered read responses back to the requester that owns the in-flight access.

Parameters:
STARVE_LIMIT, 4, consecutive DBG wait cycles before DBG is forced ahead of the CPU (1..15).
ADDR_W, 32, address width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  memory-stage access request (load or store)
cpu_we  in  1  CPU write enable
cpu_addr  in  ADDR_W  CPU byte address
cpu_wd  in  32  CPU store data
cpu_width  in  2  access width code (byte/half/word), passed through
cpu_extend  in  1  sign-extend select, passed through
cpu_stall  out  1  CPU request not granted this cycle; pipeline must hold
cpu_rvalid  out  1  CPU read data valid
cpu_rd  out  32  CPU read data
dbg_req  in  1  DBG request; held stable until dbg_gnt
dbg_we  in  1  DBG write enable
dbg_addr  in  ADDR_W  DBG byte address, word-aligned
dbg_wd  in  32  DBG write data
dbg_gnt  out  1  DBG access accepted this cycle
dbg_err  out  1  DBG request rejected (misaligned)
dbg_rvalid  out  1  DBG read data valid
dbg_rd  out  32  DBG read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wd  out  32  memory write data
mem_width  out  2  width code to memory
mem_extend  out  1  extend select to memory
mem_rd  in  32  memory read data, valid the cycle after a read strobe

Behaviour:
- Reset: clk domain only; rst_n synchronous, active-low.
  - While rst_n=0: all outputs are 0, starve_cnt=0, owner tag=NONE.
  - A read in flight when reset asserts is dropped; no rvalid follows.
- Grant decision is combinational each cycle:
  - force_dbg = (starve_cnt == STARVE_LIMIT) && dbg_req.
  - If force_dbg: grant DBG.
  - Else if cpu_req: grant CPU.
  - Else if dbg_req: grant DBG.
  - Else: no grant; mem_en=0.
- CPU grant:
  - mem_* driven from cpu_* fields; mem_en=1; cpu_stall=0.
- DBG grant:
  - mem_* driven from dbg_* fields; mem_width=word; mem_extend=0.
  - dbg_gnt=1. cpu_stall = cpu_req.
- cpu_stall = cpu_req && !CPU granted. It is asserted only in force_dbg cycles, and never for two consecutive cycles.
- Misaligned DBG address (dbg_addr[1:0] != 0) when DBG would be granted:
  - mem_en=0; dbg_gnt=1 and dbg_err=1 in the same cycle (request consumed).
  - The slot is lost. The CPU is still stalled if the cycle was forced.
- starve_cnt (registered):
  - Increments when dbg_req && !dbg_gnt; saturates at STARVE_LIMIT.
  - Clears to 0 on dbg_gnt or when !dbg_req.
- Owner tag (registered, 2 bits: NONE/CPU/DBG):
  - Set to the granted requester when the grant is a read (mem_en && !mem_we); otherwise NONE.
- Read response, cycle N+1 after a read grant in cycle N:
  - owner CPU: cpu_rvalid=1, cpu_rd=mem_rd.
  - owner DBG: dbg_rvalid=1, dbg_rd=mem_rd.
  - The *_rd outputs are 0 when the matching rvalid=0.
  - Writes produce no response.
- Back-to-back reads: each cycle's grant is tagged independently, so responses are fully pipelined at 1 per cycle.
- Simultaneous CPU and DBG requests with starve_cnt < LIMIT: CPU wins; DBG waits and its count increments.

Decomposition:
- Shared constants package:
  - owner tag encodings (OWN_NONE, OWN_CPU, OWN_DBG).
  - width codes (byte/half/word), shared with dm and controller.
- Sub-module starve_counter: saturating counter with inc/clr inputs and an at_limit output.
- Mux and tag logic stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with cpu_req=1 -> all outputs 0. Release with cpu_req=1, cpu_we=0, addr 0x10, mem_rd=0xDEADBEEF next cycle -> mem_en=1 and cpu_stall=0, then cpu_rvalid=1 with cpu_rd=0xDEADBEEF.
- DBG only: dbg_req=1, dbg_we=1, addr 0x20, wd 0x12345678 -> same-cycle dbg_gnt=1, mem_we=1, mem_width=word, mem_wd=0x12345678; starve_cnt stays 0.
- Starvation (STARVE_LIMIT=4): cpu_req and dbg_req held high -> CPU granted cycles 0-3. Cycle 4: dbg_gnt=1 and cpu_stall=1. Cycle 5: CPU granted again; starve_cnt=0.
- Interleaved reads: CPU read at cycle 3 (addr 0x40), forced DBG read at cycle 4 (addr 0x44) -> cycle 4 cpu_rvalid only; cycle 5 dbg_rvalid only. Data routed correctly with no cross-talk.
- Misaligned DBG: dbg_addr=0x22, cpu idle -> dbg_gnt=1, dbg_err=1, mem_en=0; no dbg_rvalid next cycle.
- Reset mid-read: CPU read granted in cycle N, rst_n=0 at cycle N+1 -> cpu_rvalid stays 0 and the owner tag is NONE after reset.
